mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_pkg.sv | 28 ++
 rtl/load_align.sv | 32 +++
 rtl/mem_access_unit.sv | 168 ++++++++++++++++
 tb/tb_mem_access_unit.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and constants for the memory-access stage: FSM encoding, byte-lane enables, timeout default.
package mem_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    localparam logic [3:0] BE_WORD  = 4'b1111;
    localparam logic [3:0] BE_LANE0 = 4'b0001;
    localparam logic [3:0] BE_LANE1 = 4'b0010;
    localparam logic [3:0] BE_LANE2 = 4'b0100;
    localparam logic [3:0] BE_LANE3 = 4'b1000;

    localparam int TIMEOUT_CYCLES_DEFAULT = 15;

    function automatic logic [3:0] lane_be(input logic [1:0] lane);
        logic [3:0] be;
        case (lane)
            2'd0:    be = BE_LANE0;
            2'd1:    be = BE_LANE1;
            2'd2:    be = BE_LANE2;
            default: be = BE_LANE3;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/load_align.sv
// Byte-lane steering: zero-extended load lane select, store byte replication and byte enables.
// Purely combinational, no backpressure.
module load_align
    import mem_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             byte_sel,
    input  logic [1:0]       lane,
    input  logic [WIDTH-1:0] rdata,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] load_dat,
    output logic [WIDTH-1:0] store_dat,
    output logic [3:0]       be
);

    logic [7:0] lane_byte;

    always_comb begin
        lane_byte = rdata[{lane, 3'b000} +: 8];
        if (byte_sel) begin
            load_dat  = {{(WIDTH-8){1'b0}}, lane_byte};
            store_dat = {(WIDTH/8){wdata[7:0]}};
            be        = lane_be(lane);
        end else begin
            load_dat  = rdata;
            store_dat = wdata;
            be        = BE_WORD;
        end
    end

endmodule

// File: rtl/mem_access_unit.sv
// EX/MEM register plus memory-access FSM; retires non-memory ops 1 cycle after capture, memory ops on mem_ready.
// StallM holds upstream while an access waits; optional access timeout under MEM_TIMEOUT_EN.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ValidE,
    input  logic             RegWriteE,
    input  logic             MemWriteE,
    input  logic             MemtoRegE,
    input  logic             ByteE,
    input  logic [WIDTH-1:0] ALUResultE,
    input  logic [WIDTH-1:0] WriteDataE,
    input  logic [3:0]       WA3E,
    output logic             mem_req,
    output logic             mem_we,
    output logic [3:0]       mem_be,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic [WIDTH-1:0] mem_rdata,
    input  logic             mem_ready,
    output logic             StallM,
    output logic             ValidM,
    output logic             RegWriteM,
    output logic             MemtoRegM,
    output logic             MemErrM,
    output logic [WIDTH-1:0] ALUOutM,
    output logic [WIDTH-1:0] ReadDataM,
    output logic [3:0]       WA3M
);

    state_t           state_q, state_d;
    logic             valid_q, valid_d;
    logic             reg_write_q, reg_write_d;
    logic             mem_write_q, mem_write_d;
    logic             mem_to_reg_q, mem_to_reg_d;
    logic             byte_q, byte_d;
    logic [WIDTH-1:0] alu_out_q, alu_out_d;
    logic [WIDTH-1:0] write_data_q, write_data_d;
    logic [3:0]       wa3_q, wa3_d;

    logic             access;
    logic             capture;
    logic             retire;
    logic             timeout_hit;
    logic [WIDTH-1:0] load_dat;
    logic [WIDTH-1:0] store_dat;
    logic [3:0]       be;

    assign access = (state_q == ACCESS);

`ifdef MEM_TIMEOUT_EN
    localparam int              CW     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0]   TO_LIM = CW'(TIMEOUT_CYCLES);

    logic [CW-1:0] cnt_q, cnt_d;

    // Counter saturates at the limit; the limit cycle itself is the error retirement.
    always_comb begin
        timeout_hit = access & ~mem_ready & (cnt_q == TO_LIM);
        cnt_d       = cnt_q;
        if (capture) begin
            cnt_d = '0;
        end else if (access && !mem_ready && cnt_q != TO_LIM) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = |TIMEOUT_CYCLES;

    always_comb begin
        timeout_hit = 1'b0;
    end
`endif

    // State register and EX/MEM pipeline register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= IDLE;
            valid_q      <= 1'b0;
            reg_write_q  <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
            byte_q       <= 1'b0;
            alu_out_q    <= '0;
            write_data_q <= '0;
            wa3_q        <= '0;
        end else begin
            state_q      <= state_d;
            valid_q      <= valid_d;
            reg_write_q  <= reg_write_d;
            mem_write_q  <= mem_write_d;
            mem_to_reg_q <= mem_to_reg_d;
            byte_q       <= byte_d;
            alu_out_q    <= alu_out_d;
            write_data_q <= write_data_d;
            wa3_q        <= wa3_d;
        end
    end

    // Next state: a free stage always takes the incoming instruction.
    always_comb begin
        capture      = ~StallM;
        state_d      = state_q;
        valid_d      = valid_q;
        reg_write_d  = reg_write_q;
        mem_write_d  = mem_write_q;
        mem_to_reg_d = mem_to_reg_q;
        byte_d       = byte_q;
        alu_out_d    = alu_out_q;
        write_data_d = write_data_q;
        wa3_d        = wa3_q;
        if (capture) begin
            state_d      = (ValidE && (MemWriteE || MemtoRegE)) ? ACCESS : IDLE;
            valid_d      = ValidE;
            reg_write_d  = RegWriteE;
            mem_write_d  = MemWriteE;
            mem_to_reg_d = MemtoRegE;
            byte_d       = ByteE;
            alu_out_d    = ALUResultE;
            write_data_d = WriteDataE;
            wa3_d        = WA3E;
        end
    end

    load_align #(
        .WIDTH (WIDTH)
    ) u_load_align (
        .byte_sel  (byte_q),
        .lane      (alu_out_q[1:0]),
        .rdata     (mem_rdata),
        .wdata     (write_data_q),
        .load_dat  (load_dat),
        .store_dat (store_dat),
        .be        (be)
    );

    always_comb begin
        StallM    = access & ~mem_ready & ~timeout_hit;
        retire    = (~access & valid_q) | (access & (mem_ready | timeout_hit));
        ValidM    = retire;
        MemErrM   = timeout_hit;
        RegWriteM = reg_write_q & retire & ~timeout_hit;
        MemtoRegM = mem_to_reg_q;
        ALUOutM   = alu_out_q;
        WA3M      = wa3_q;
        ReadDataM = (access && mem_to_reg_q) ? load_dat : '0;
        mem_req   = access;
        mem_we    = mem_write_q;
        mem_addr  = {alu_out_q[WIDTH-1:2], 2'b00};
        mem_wdata = store_dat;
        mem_be    = be;
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: instruction-level reference model checked every cycle, plus directed literal cases.
module tb_mem_access_unit;

    localparam int W  = 32;
    localparam int TO = 15;

    logic          clk = 1'b0;
    logic          reset;
    logic          ValidE, RegWriteE, MemWriteE, MemtoRegE, ByteE;
    logic [W-1:0]  ALUResultE, WriteDataE;
    logic [3:0]    WA3E;
    logic          mem_req, mem_we;
    logic [3:0]    mem_be;
    logic [W-1:0]  mem_addr, mem_wdata, mem_rdata;
    logic          mem_ready;
    logic          StallM, ValidM, RegWriteM, MemtoRegM, MemErrM;
    logic [W-1:0]  ALUOutM, ReadDataM;
    logic [3:0]    WA3M;

    always #5 clk = ~clk;

    mem_access_unit #(
        .WIDTH          (W),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .ValidE     (ValidE),
        .RegWriteE  (RegWriteE),
        .MemWriteE  (MemWriteE),
        .MemtoRegE  (MemtoRegE),
        .ByteE      (ByteE),
        .ALUResultE (ALUResultE),
        .WriteDataE (WriteDataE),
        .WA3E       (WA3E),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_be     (mem_be),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready),
        .StallM     (StallM),
        .ValidM     (ValidM),
        .RegWriteM  (RegWriteM),
        .MemtoRegM  (MemtoRegM),
        .MemErrM    (MemErrM),
        .ALUOutM    (ALUOutM),
        .ReadDataM  (ReadDataM),
        .WA3M       (WA3M)
    );

    typedef struct packed {
        logic        v;
        logic        rw;
        logic        mw;
        logic        m2r;
        logic        byt;
        logic [31:0] alu;
        logic [31:0] wd;
        logic [3:0]  wa3;
    } ins_t;

    ins_t m;            // instruction currently occupying the memory stage
    int   m_wait;       // cycles it has waited on memory so far
    bit   chk_on = 1'b0;
    int   n_chk  = 0;
    int   n_pass = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%h, expected 0x%h at %0t", name, act, exp, $time);
    endtask

    function automatic ins_t presented();
        ins_t p;
        p.v   = ValidE;
        p.rw  = RegWriteE;
        p.mw  = MemWriteE;
        p.m2r = MemtoRegE;
        p.byt = ByteE;
        p.alu = ALUResultE;
        p.wd  = WriteDataE;
        p.wa3 = WA3E;
        return p;
    endfunction

    function automatic bit is_mem(input ins_t i);
        return i.v && (i.mw || i.m2r);
    endfunction

    function automatic bit timed_out();
`ifdef MEM_TIMEOUT_EN
        return is_mem(m) && !mem_ready && (m_wait >= TO);
`else
        return 1'b0;
`endif
    endfunction

    // Reference model: the stage accepts a new instruction whenever its occupant is not waiting on memory.
    always @(posedge clk) begin
        if (!reset) begin
            m      = '0;
            m_wait = 0;
        end else if (is_mem(m) && !mem_ready && !timed_out()) begin
            m_wait++;
        end else begin
            m      = presented();
            m_wait = 0;
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            bit          mem_op, to, done;
            logic [31:0] exp_rd;
            mem_op = is_mem(m);
            to     = timed_out();
            done   = m.v && (!mem_op || mem_ready || to);
            exp_rd = 32'h0;
            if (mem_op && m.m2r)
                exp_rd = m.byt ? ((mem_rdata >> (8 * m.alu[1:0])) & 32'hff) : mem_rdata;
            check("StallM",    StallM,    mem_op && !mem_ready && !to);
            check("ValidM",    ValidM,    done);
            check("RegWriteM", RegWriteM, done && m.rw && !to);
            check("MemErrM",   MemErrM,   to);
            check("mem_req",   mem_req,   mem_op);
            check("ALUOutM",   ALUOutM,   m.alu);
            check("WA3M",      WA3M,      m.wa3);
            check("MemtoRegM", MemtoRegM, m.m2r);
            check("ReadDataM", ReadDataM, exp_rd);
            if (mem_op) begin
                check("mem_addr",  mem_addr,  m.alu & 32'hffff_fffc);
                check("mem_we",    mem_we,    m.mw);
                check("mem_be",    mem_be,    m.byt ? (32'h1 << m.alu[1:0]) : 32'hf);
                check("mem_wdata", mem_wdata, m.byt ? (m.wd[7:0] * 32'h0101_0101) : m.wd);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic v, input logic rw, input logic mw, input logic m2r,
                       input logic byt, input logic [31:0] alu, input logic [31:0] wd,
                       input logic [3:0] wa3);
        ValidE     = v;
        RegWriteE  = rw;
        MemWriteE  = mw;
        MemtoRegE  = m2r;
        ByteE      = byt;
        ALUResultE = alu;
        WriteDataE = wd;
        WA3E       = wa3;
    endtask

    task automatic bubble();
        put(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    endtask

    task automatic put_rand();
        put(($urandom % 5) != 0, 1'($urandom), ($urandom % 10) < 3, ($urandom % 10) < 3,
            1'($urandom), $urandom, $urandom, 4'($urandom));
    endtask

    initial begin
        int stalls;
        reset     = 1'b0;
        mem_ready = 1'b0;
        mem_rdata = 32'h0;
        bubble();
        cyc();
        cyc();
        chk_on = 1'b1;
        @(negedge clk);
        check("rst_mem_req",   mem_req,   0);
        check("rst_StallM",    StallM,    0);
        check("rst_ValidM",    ValidM,    0);
        check("rst_RegWriteM", RegWriteM, 0);
        check("rst_MemErrM",   MemErrM,   0);
        cyc();
        reset = 1'b1;

        // ALU op retires the cycle after capture
        put(1, 1, 0, 0, 0, 32'h10, 32'h0, 4'd3);
        cyc();
        bubble();
        @(negedge clk);
        check("alu_ValidM",    ValidM,    1);
        check("alu_RegWriteM", RegWriteM, 1);
        check("alu_ALUOutM",   ALUOutM,   32'h10);
        check("alu_WA3M",      WA3M,      4'd3);
        check("alu_StallM",    StallM,    0);
        cyc();

        // Word load with three wait cycles
        put(1, 1, 0, 1, 0, 32'h104, 32'h0, 4'd5);
        cyc();
        bubble();
        stalls = 0;
        repeat (3) begin
            @(negedge clk);
            if (StallM === 1'b1) stalls++;
            cyc();
        end
        mem_ready = 1'b1;
        mem_rdata = 32'hDEADBEEF;
        @(negedge clk);
        check("ldw_stall_cycles", stalls,    3);
        check("ldw_ValidM",       ValidM,    1);
        check("ldw_ReadDataM",    ReadDataM, 32'hDEADBEEF);
        check("ldw_mem_be",       mem_be,    4'b1111);
        check("ldw_mem_addr",     mem_addr,  32'h104);
        cyc();
        mem_ready = 1'b0;

        // Byte store to lane 3
        put(1, 0, 1, 0, 1, 32'h203, 32'hAB, 4'd0);
        cyc();
        bubble();
        mem_ready = 1'b1;
        @(negedge clk);
        check("stb_mem_be",    mem_be,    4'b1000);
        check("stb_mem_wdata", mem_wdata, 32'hABABABAB);
        check("stb_mem_we",    mem_we,    1);
        check("stb_RegWriteM", RegWriteM, 0);
        check("stb_mem_addr",  mem_addr,  32'h200);
        cyc();
        mem_ready = 1'b0;

        // Byte load from lane 1
        put(1, 1, 0, 1, 1, 32'h201, 32'h0, 4'd7);
        cyc();
        bubble();
        mem_ready = 1'b1;
        mem_rdata = 32'h11223344;
        @(negedge clk);
        check("ldb_ReadDataM", ReadDataM, 32'h00000033);
        cyc();
        mem_ready = 1'b0;

        // Back-to-back zero-wait loads
        put(1, 1, 0, 1, 0, 32'h300, 32'h0, 4'd1);
        cyc();
        put(1, 1, 0, 1, 0, 32'h304, 32'h0, 4'd2);
        mem_ready = 1'b1;
        mem_rdata = 32'hA1A1A1A1;
        @(negedge clk);
        check("b2b_first_ValidM", ValidM, 1);
        check("b2b_first_StallM", StallM, 0);
        cyc();
        bubble();
        mem_rdata = 32'hB2B2B2B2;
        @(negedge clk);
        check("b2b_second_ValidM",  ValidM,    1);
        check("b2b_second_StallM",  StallM,    0);
        check("b2b_second_mem_req", mem_req,   1);
        check("b2b_second_addr",    mem_addr,  32'h304);
        check("b2b_second_rdata",   ReadDataM, 32'hB2B2B2B2);
        cyc();
        mem_ready = 1'b0;

        // Long wait: error retirement with the timeout, indefinite wait without it
        put(1, 1, 0, 1, 0, 32'h500, 32'h0, 4'd9);
        cyc();
        bubble();
        stalls = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (ValidM === 1'b1 || (stalls >= 20 && MemErrM !== 1'b1)) break;
            if (StallM === 1'b1) stalls++;
            cyc();
        end
`ifdef MEM_TIMEOUT_EN
        check("to_wait_cycles", stalls,    TO);
        check("to_MemErrM",     MemErrM,   1);
        check("to_RegWriteM",   RegWriteM, 0);
        check("to_ValidM",      ValidM,    1);
        cyc();
`else
        check("wait_stall_cycles", stalls,  20);
        check("wait_MemErrM",      MemErrM, 0);
        check("wait_StallM",       StallM,  1);
        cyc();
        mem_ready = 1'b1;
        cyc();
        mem_ready = 1'b0;
`endif

        // Reset in the middle of an access abandons it
        put(1, 1, 0, 1, 0, 32'h400, 32'h0, 4'd4);
        cyc();
        bubble();
        cyc();
        reset = 1'b0;
        cyc();
        @(negedge clk);
        check("rstacc_mem_req", mem_req, 0);
        check("rstacc_ValidM",  ValidM,  0);
        check("rstacc_StallM",  StallM,  0);
        cyc();
        reset = 1'b1;

        // Random traffic, random memory latency, ready also toggling while idle
        repeat (3000) begin
            cyc();
            put_rand();
            mem_ready = 1'($urandom);
            mem_rdata = $urandom;
            reset     = ($urandom % 150) != 0;
        end
        cyc();
        reset     = 1'b1;
        mem_ready = 1'b1;
        bubble();
        repeat (3) cyc();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
